rr_tdm_scheduler: RTL
=====================

Name: rr_tdm_scheduler

Overview:
- Round-robin time-division scheduler that shares the single-wire 4:1 mux / 1:4 demux path between 4 requesters.
- Generates the 2-bit select for both mux and demux and the one-hot grant.
- Holds each grant for a bounded slot, then rotates to the next requesting channel.
- Sits between the channel request logic and the mux/demux datapath; drives S and gates the routed data.

Parameters:
- NUM_CH, 4, number of channels; fixed at 4 in this revision, SEL_W = 2.
- SLOT_CYCLES, 8, maximum grant length in clock cycles; legal range 1..255.
- CNT_W, 8, width of the slot counter; must satisfy 2**CNT_W >= SLOT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  per-channel request, level-sensitive.
- data_in  in  4  per-channel data bit, feeds the mux.
- sel  out  SEL_W  select driven to mux S and demux S.
- grant  out  4  one-hot grant; all zeros when idle.
- busy  out  1  high while any grant is active.
- slot_done  out  1  one-cycle pulse on the cycle after a slot ends.
- data_out  out  4  demux output: data_out[sel] = data_in[sel] when busy; all other bits 0.

Behaviour:
- Reset values (rst high at a clock edge): state=IDLE, sel=0, grant=0, busy=0, slot_done=0, counter=0, last-served pointer=3, so the first search starts at channel 0.
- States:
  - IDLE: no grant active.
  - SERVE: one channel granted.
- IDLE -> SERVE: at an edge where req != 0.
  - The chosen channel is the first set req bit scanning last+1, last+2, ... modulo 4.
  - sel=chosen, grant=1<<chosen, busy=1, counter=0. Latency from req to grant is 1 cycle.
- In SERVE, the counter increments each cycle. The slot ends at the edge where either:
  - counter == SLOT_CYCLES-1, or
  - req[sel] == 0 (early release: the requester dropped its request).
- At slot end:
  - last := sel, and slot_done=1 for exactly the next cycle.
  - If any req is set (including the current one), pick the next channel by rotation from last+1 and stay in SERVE with counter=0. Handover is back-to-back with no idle cycle.
  - If req == 0, go to IDLE: grant=0, busy=0, sel holds its last value.
- Single active requester: it is re-granted every slot; slot_done still pulses at each boundary.
- SLOT_CYCLES=1: every cycle is a slot boundary; grants rotate each cycle among the requesters.
- Simultaneous early release and counter expiry are treated as one slot end with a single slot_done pulse.
- data_out is combinational from the registered sel and busy plus the live data_in; there is no added latency through the mux/demux path.
- Reset asserted mid-slot overrides everything. Outputs return to reset values at that edge and no slot_done pulse is emitted.
- grant is always zero or one-hot; sel always equals the index of the set grant bit while busy.

Optional Feature:
- Macro: RR_TDM_LOCK_EN.
- Defined: adds input port lock (1 bit). While in SERVE with lock=1 and req[sel]=1, counter expiry is ignored and the counter saturates at SLOT_CYCLES-1. Early release on req[sel]=0 still ends the slot. Expiry takes effect on the first edge after lock falls.
- Undefined: no lock port; slots always end at SLOT_CYCLES.

Decomposition:
- Package rr_tdm_pkg:
  - Constants NUM_CH=4, SEL_W=2.
  - State enum with IDLE and SERVE.
  - Function next_rr(req, last) returning the selected index and a found flag.
- One natural sub-module: rr_pick, a combinational rotating-priority encoder (req[3:0], last[1:0] -> idx[1:0], found).
- The mux/demux datapath stays a separate instance. The scheduler drives its sel and gates its output with busy.

Test Plan (SLOT_CYCLES=4):
- Reset then req=0000 for 10 cycles -> busy=0, grant=0000, sel=00, slot_done never pulses.
- req=0001 held -> grant=0001 one cycle after req rises. slot_done pulses every 4 cycles, grant stays 0001, no gap between slots.
- req=1111 held -> grant sequence 0001,0010,0100,1000,0001, each held 4 cycles. data_in=1010 gives data_out=0000,0010,0000,1000 per slot.
- req=0101, then drop req[0] at cycle 2 of its slot -> slot ends that edge, grant=0100 next cycle, slot_done=1 for one cycle.
- rst pulsed in the middle of a channel-2 grant -> grant=0000, sel=00 at the reset edge. With req=1111 after release, the first grant is 0001.
- RR_TDM_LOCK_EN defined, req=0011, lock=1 for 10 cycles during the channel-0 slot -> grant=0001 held for 10+ cycles. It moves to 0010 on the first edge after lock falls.

Source files
------------

// File: rtl/rr_tdm_pkg.sv
// Shared constants, FSM state type and rotating-priority search
// for the round-robin TDM scheduler.
package rr_tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First set request scanning last+1, last+2, ... wrapping mod NUM_CH.
    // Iterating from the farthest offset down lets the nearest one win.
    function automatic pick_t next_rr(
        input logic [NUM_CH-1:0] req,
        input logic [SEL_W-1:0]  last
    );
        pick_t            p;
        logic [SEL_W-1:0] c;
        p.found = 1'b0;
        p.idx   = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            c = last + SEL_W'(i);
            if (req[c]) begin
                p.found = 1'b1;
                p.idx   = c;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_tdm_scheduler_pick.sv
// Combinational rotating-priority encoder: picks the next
// requesting channel after 'last'.
module rr_pick
    import rr_tdm_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);

    pick_t p;

    // Search is a pure function of the request vector and pointer.
    always_comb begin
        p     = next_rr(req, last);
        idx   = p.idx;
        found = p.found;
    end

endmodule

// File: rtl/rr_tdm_scheduler.sv
// Round-robin TDM scheduler driving mux/demux select and grant.
// Optional RR_TDM_LOCK_EN adds a 'lock' input that extends a slot.
module rr_tdm_scheduler
    import rr_tdm_pkg::*;
#(
    parameter int SLOT_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] data_in,
`ifdef RR_TDM_LOCK_EN
    input  logic              lock,
`endif
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] grant,
    output logic              busy,
    output logic              slot_done,
    output logic [NUM_CH-1:0] data_out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [SEL_W-1:0] pick_last;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             hold;
    logic             at_last;
    logic             slot_end;

    // While serving, the rotation restarts after the current channel,
    // which is exactly what 'last' becomes at the slot end.
    assign pick_last = (state_q == SERVE) ? sel_q : last_q;

    rr_pick u_pick (
        .req   (req),
        .last  (pick_last),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef RR_TDM_LOCK_EN
    assign hold = lock && req[sel_q];
`else
    assign hold = 1'b0;
`endif

    assign at_last  = (cnt_q == LAST_CNT);
    assign slot_end = !req[sel_q] || (at_last && !hold);

    // State, select, pointer, slot counter and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_CH - 1);
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state: grant on request, rotate or idle at each slot end.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = SERVE;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            SERVE: begin
                if (slot_end) begin
                    last_d = sel_q;
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (pick_found) begin
                        sel_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!at_last) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Outputs decode from registered state; the data path has no latency.
    always_comb begin
        busy      = (state_q == SERVE);
        sel       = sel_q;
        slot_done = done_q;
        grant     = busy ? (NUM_CH'(1) << sel_q) : '0;
        data_out  = data_in & grant;
    end

endmodule
